// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the memory request arbiter.
//   arb_state_t : arbiter FSM state encoding
//   ARB_FIXED   : lowest-index-wins arbitration
//   ARB_RR      : round-robin arbitration
//   ch_idx_w()  : width of a channel index (clog2 of channel count, minimum 1)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational winner selection.
//   active    in  NUM_CH  per-channel request (read | write)
//   ptr       in  IW      last granted channel (round-robin only)
//   grant     out NUM_CH  one-hot winner
//   grant_idx out IW      index of the winner
//   grant_vld out 1       any channel active
// ARB_MODE=ARB_RR searches from ptr+1 with wrap; otherwise the lowest
// active index wins and ptr is ignored.
module arb_rr_pick import mem_arb_pkg::*; #(
  parameter int NUM_CH   = 2,
  parameter int ARB_MODE = 0,
  parameter int IW       = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] active,
  input  logic [IW-1:0]     ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IW-1:0]     grant_idx,
  output logic              grant_vld
);

  logic [IW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = '0;
    if (ARB_MODE == ARB_RR) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        idx = IW'((int'(ptr) + i) % NUM_CH);
        if (!grant_vld && active[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = idx;
          grant_vld  = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        idx = IW'(i);
        if (!grant_vld && active[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = idx;
          grant_vld  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one variable-latency memory bus between NUM_CH
// requesters. Each completed access returns a one-cycle req_ready pulse.
//   clk, rst            clock, synchronous active-high reset
//   req_read/req_write  per-channel request, held until ready
//   req_addr/req_wdata  packed per-channel address/write data, ch0 in LSBs
//   req_ready/req_err   one-hot completion / abort pulse
//   req_rdata           read data, valid with req_ready, held until next RESP
//   bus_read/bus_write  bus strobes, held through WAIT
//   bus_addr/bus_wdata  latched at grant
//   bus_rdata/bus_ack   bus response
// Optional: define MEM_ARB_WATCHDOG_EN to abort a WAIT that sees no ack
// within TIMEOUT_CYC cycles (req_err pulses with req_ready, req_rdata=0).
//
// state | meaning
// IDLE  | no access in flight; grant the arbitration winner if any
// WAIT  | strobe held on the bus until bus_ack (or watchdog timeout)
// RESP  | one-cycle req_ready pulse to the winner
module mem_req_arbiter import mem_arb_pkg::*; #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_read,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        req_err,
  output logic [DATA_W-1:0]        req_rdata,
  output logic                     bus_read,
  output logic                     bus_write,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W-1:0]        bus_wdata,
  input  logic [DATA_W-1:0]        bus_rdata,
  input  logic                     bus_ack
);

  localparam int IW = ch_idx_w(NUM_CH);

  arb_state_t        state;
  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] pick_oh;
  logic [NUM_CH-1:0] win_oh;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     rr_ptr;
  logic              pick_vld;
  logic              wd_hit;

  logic [ADDR_W-1:0] addr_arr  [NUM_CH];
  logic [DATA_W-1:0] wdata_arr [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  assign active = req_read | req_write;

  arb_rr_pick #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE),
    .IW       (IW)
  ) u_pick (
    .active    (active),
    .ptr       (rr_ptr),
    .grant     (pick_oh),
    .grant_idx (pick_idx),
    .grant_vld (pick_vld)
  );

`ifdef MEM_ARB_WATCHDOG_EN
  localparam int WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WDW-1:0] wd_cnt;
  assign wd_hit = (wd_cnt == WDW'(TIMEOUT_CYC - 1));
`else
  assign wd_hit  = 1'b0;
  assign req_err = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= IW'(NUM_CH - 1);
      win_oh    <= '0;
      bus_read  <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      req_ready <= '0;
      req_rdata <= '0;
`ifdef MEM_ARB_WATCHDOG_EN
      wd_cnt    <= '0;
      req_err   <= '0;
`endif
    end else begin
      req_ready <= '0;
`ifdef MEM_ARB_WATCHDOG_EN
      req_err   <= '0;
`endif
      case (state)
        IDLE: begin
          if (pick_vld) begin
            win_oh    <= pick_oh;
            rr_ptr    <= pick_idx;
            bus_addr  <= addr_arr[pick_idx];
            bus_wdata <= wdata_arr[pick_idx];
            // read+write on the same channel is a write
            bus_write <= req_write[pick_idx];
            bus_read  <= !req_write[pick_idx];
`ifdef MEM_ARB_WATCHDOG_EN
            wd_cnt    <= '0;
`endif
            state     <= WAIT;
          end
        end
        WAIT: begin
          // ack is checked first so an ack coincident with timeout completes normally
          if (bus_ack) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            req_rdata <= bus_write ? '0 : bus_rdata;
            req_ready <= win_oh;
            state     <= RESP;
          end else if (wd_hit) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            req_rdata <= '0;
            req_ready <= win_oh;
`ifdef MEM_ARB_WATCHDOG_EN
            req_err   <= win_oh;
`endif
            state     <= RESP;
          end
`ifdef MEM_ARB_WATCHDOG_EN
          else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;

  localparam int NCH = 2;
  localparam int TO  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH-1:0]  req_read, req_write;
  logic [NCH*32-1:0] req_addr, req_wdata;
  logic [31:0]     bus_rdata;
  logic            bus_ack;

  logic [NCH-1:0]  req_ready_f, req_err_f, req_ready_r, req_err_r;
  logic [31:0]     req_rdata_f, req_rdata_r;
  logic            bus_read_f, bus_write_f, bus_read_r, bus_write_r;
  logic [31:0]     bus_addr_f, bus_wdata_f, bus_addr_r, bus_wdata_r;

  always #5 clk = ~clk;

  mem_req_arbiter #(.NUM_CH(NCH), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT_CYC(TO)) dut_f (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_f),
    .req_err(req_err_f), .req_rdata(req_rdata_f), .bus_read(bus_read_f),
    .bus_write(bus_write_f), .bus_addr(bus_addr_f), .bus_wdata(bus_wdata_f),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack));

  mem_req_arbiter #(.NUM_CH(NCH), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT_CYC(TO)) dut_r (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_r),
    .req_err(req_err_r), .req_rdata(req_rdata_r), .bus_read(bus_read_r),
    .bus_write(bus_write_r), .bus_addr(bus_addr_r), .bus_wdata(bus_wdata_r),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack));

  typedef struct {
    int          ch;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brdata;
    int          ack_cyc;    // WAIT cycle carrying bus_ack (1-based), 0 = never
    logic        exp_write;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    int          ch;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q_f[$];
  exp_t q_r[$];
  exp_t ef, er;
  vec_t vecs[6];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every ready/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready_f != 0 || req_err_f != 0) begin
        if (q_f.size() == 0) chk("sb_f_unexpected", {req_err_f, req_ready_f}, 0);
        else begin
          ef = q_f.pop_front();
          chk("sb_f_ready", req_ready_f, 2'b01 << ef.ch);
          chk("sb_f_err", req_err_f, ef.err ? (2'b01 << ef.ch) : 2'b00);
          chk("sb_f_rdata", req_rdata_f, ef.rdata);
        end
      end
      if (req_ready_r != 0 || req_err_r != 0) begin
        if (q_r.size() == 0) chk("sb_r_unexpected", {req_err_r, req_ready_r}, 0);
        else begin
          er = q_r.pop_front();
          chk("sb_r_ready", req_ready_r, 2'b01 << er.ch);
          chk("sb_r_err", req_err_r, er.err ? (2'b01 << er.ch) : 2'b00);
          chk("sb_r_rdata", req_rdata_r, er.rdata);
        end
      end
    end
  end

  task automatic push_both(input int ch, input logic [31:0] rd, input logic err);
    q_f.push_back('{ch, rd, err});
    q_r.push_back('{ch, rd, err});
  endtask

  // Single-channel access, cycle-checked from request to ready.
  task automatic do_txn(input vec_t v);
    int          exp_wait;
    logic        err;
    logic [31:0] exp_rd;
    logic [1:0]  exp_str;
    logic        in_wait;
    exp_wait = v.ack_cyc;
    err      = 1'b0;
`ifdef MEM_ARB_WATCHDOG_EN
    if (v.ack_cyc == 0 || v.ack_cyc > TO) begin
      exp_wait = TO;
      err      = 1'b1;
    end
`endif
    exp_rd = err ? 32'h0 : v.exp_rdata;
    req_read[v.ch]            = v.rd;
    req_write[v.ch]           = v.wr;
    req_addr[v.ch*32 +: 32]   = v.addr;
    req_wdata[v.ch*32 +: 32]  = v.wdata;
    push_both(v.ch, exp_rd, err);
    for (int c = 0; c <= exp_wait + 1; c++) begin
      @(negedge clk);
      in_wait = (c >= 1 && c <= exp_wait);
      exp_str = in_wait ? (v.exp_write ? 2'b10 : 2'b01) : 2'b00;
      chk("strobe_f", {bus_write_f, bus_read_f}, exp_str);
      chk("strobe_r", {bus_write_r, bus_read_r}, exp_str);
      if (in_wait) begin
        chk("bus_addr", bus_addr_f, v.addr);
        chk("bus_wdata", bus_wdata_f, v.wdata);
      end
      chk("ready_lat_f", req_ready_f[v.ch], c == exp_wait + 1);
      chk("ready_lat_r", req_ready_r[v.ch], c == exp_wait + 1);
      bus_ack   = in_wait && (c == v.ack_cyc);
      bus_rdata = v.brdata;
    end
    @(posedge clk); #1;
    req_read  = '0;
    req_write = '0;
    bus_ack   = 1'b0;
    @(negedge clk);
    chk("rdata_hold", req_rdata_f, exp_rd);
    chk("ready_single", req_ready_f, 0);
    @(posedge clk); #1;
  endtask

  // Acks every access in its first WAIT cycle until n readies on dut_f.
  task automatic serve(input int n, input logic [31:0] rdata);
    int cnt;
    cnt = 0;
    for (int c = 0; c < 3*n + 6; c++) begin
      @(negedge clk);
      bus_rdata = rdata;
      bus_ack   = bus_read_f | bus_write_f;
      if (req_ready_f != 0) cnt++;
      if (cnt == n) break;
    end
    chk("serve_count", cnt, n);
    @(posedge clk); #1;
    req_read  = '0;
    req_write = '0;
    bus_ack   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0000_03E8, 1, 1'b0, 32'h0000_03E8};
    vecs[1] = '{1, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_5555, 4, 1'b1, 32'h0000_0000};
    vecs[2] = '{1, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_1234, 32'h0000_AAAA, 2, 1'b1, 32'h0000_0000};
    vecs[3] = '{0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h5A5A_5A5A, 32'hCAFE_F00D, 3, 1'b0, 32'hCAFE_F00D};
    vecs[4] = '{1, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h0BAD_F00D, 1, 1'b0, 32'h0BAD_F00D};
    vecs[5] = '{0, 1'b0, 1'b1, 32'h0000_0008, 32'h1357_9BDF, 32'h0000_7777, TO, 1'b1, 32'h0000_0000};

    rst       = 1'b1;
    req_read  = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    bus_rdata = 32'h0;
    bus_ack   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", {bus_read_f, bus_write_f, bus_read_r, bus_write_r}, 0);
    chk("rst_ready", {req_ready_f, req_ready_r, req_err_f, req_err_r}, 0);
    chk("rst_rdata", {req_rdata_f, req_rdata_r}, 0);
    chk("rst_addr", {bus_addr_f, bus_addr_r}, 0);
    chk("rst_wdata", {bus_wdata_f, bus_wdata_r}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // bus_ack with nothing in flight is ignored
    bus_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ack_strobe", {bus_write_f, bus_read_f, bus_write_r, bus_read_r}, 0);
      chk("idle_ack_ready", {req_ready_f, req_ready_r}, 0);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;

    // both channels requesting continuously: fixed always ch0, round-robin alternates
    req_addr = {32'h0000_2000, 32'h0000_1000};
    req_read = 2'b11;
    for (int i = 0; i < 4; i++) begin
      q_f.push_back('{0, 32'h77, 1'b0});
      q_r.push_back('{i % 2, 32'h77, 1'b0});
    end
    serve(4, 32'h77);

    for (int i = 0; i < 6; i++) do_txn(vecs[i]);

    // rst during WAIT aborts silently; afterwards ch0 is favoured again
    req_addr[31:0] = 32'h0000_3000;
    req_read       = 2'b01;
    @(negedge clk);
    chk("rstmid_idle", {bus_read_f, bus_read_r}, 0);
    @(negedge clk);
    chk("rstmid_wait", {bus_read_f, bus_read_r}, 2'b11);
    rst = 1'b1;
    @(posedge clk); #1;
    rst            = 1'b0;
    req_addr[63:32] = 32'h0000_4000;
    req_read       = 2'b11;
    @(negedge clk);
    chk("rstmid_drop", {bus_write_f, bus_read_f, bus_write_r, bus_read_r}, 0);
    chk("rstmid_noready", {req_ready_f, req_ready_r, req_err_f, req_err_r}, 0);
    push_both(0, 32'h99, 1'b0);
    serve(1, 32'h99);

`ifdef MEM_ARB_WATCHDOG_EN
    begin
      vec_t wv;
      wv = '{0, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 32'hFFFF_0000, 0, 1'b0, 32'h0};
      do_txn(wv);
    end
`endif

    repeat (2) @(negedge clk);
    chk("sb_f_drained", q_f.size(), 0);
    chk("sb_r_drained", q_r.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
